// File: rtl/fsk_demod.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fsk_demod
// Brief   : Binary FSK demodulator that classifies carrier half-period widths
//           into mark/space bits and reports carrier presence. Defining
//           FSK_DEMOD_MAJORITY_EN adds a 3-decision majority vote on data_out.
// Revision: 1.0 - initial release
// ============================================================================
module fsk_demod #(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned THRESH   = 166,
  parameter int unsigned MIN_HALF = 100,
  parameter int unsigned MAX_HALF = 250,
  parameter int unsigned TIMEOUT  = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic fsk_in,
  output logic data_out,
  output logic carrier_ok
);

  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_THRESH   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] C_MIN_HALF = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] C_MAX_HALF = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);

  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             decide_q, decide_d;
  logic             data_q, data_d;
  logic             carrier_q, carrier_d;

  logic edge_det;
  logic timeout;
  logic in_range;
  logic too_long;
  logic bit_dec;

`ifdef FSK_DEMOD_MAJORITY_EN
  logic [2:0] hist_q, hist_d;
`endif

  always_comb begin
    // sync_q[0..1] form the metastability synchronizer; sync_q[2] is the edge-detect delay
    sync_d   = {sync_q[1:0], fsk_in};
    edge_det = sync_q[1] ^ sync_q[2];

    cnt_d    = cnt_q;
    sample_d = sample_q;
    if (edge_det) begin
      sample_d = cnt_q;
      cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    decide_d = edge_det;
    timeout  = !edge_det && (cnt_q == C_TIMEOUT);
    in_range = (sample_q >= C_MIN_HALF) && (sample_q <= C_MAX_HALF);
    too_long = (sample_q > C_MAX_HALF);
    bit_dec  = (sample_q < C_THRESH);

    carrier_d = carrier_q;
    if (timeout) begin
      carrier_d = 1'b0;
    end else if (decide_q && in_range) begin
      carrier_d = 1'b1;
    end else if (decide_q && too_long) begin
      carrier_d = 1'b0;
    end

`ifdef FSK_DEMOD_MAJORITY_EN
    hist_d = hist_q;
    if (timeout) begin
      hist_d = 3'b000;
    end else if (decide_q && in_range) begin
      hist_d = {hist_q[1:0], bit_dec};
    end
    data_d = timeout ? 1'b0
                     : ((hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]));
`else
    data_d = data_q;
    if (timeout) begin
      data_d = 1'b0;
    end else if (decide_q && in_range) begin
      data_d = bit_dec;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 3'b000;
      cnt_q     <= '0;
      sample_q  <= '0;
      decide_q  <= 1'b0;
      data_q    <= 1'b0;
      carrier_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      decide_q  <= decide_d;
      data_q    <= data_d;
      carrier_q <= carrier_d;
    end
  end

`ifdef FSK_DEMOD_MAJORITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 3'b000;
    end else begin
      hist_q <= hist_d;
    end
  end
`endif

  assign data_out   = data_q;
  assign carrier_ok = carrier_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_demod.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fsk_demod
// Brief   : Scoreboard bench for fsk_demod; a half-period level model predicts
//           data_out/carrier_ok after every fsk_in transition and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fsk_demod;

  localparam int TIMEOUT  = 512;
  localparam int THRESH   = 166;
  localparam int MIN_HALF = 100;
  localparam int MAX_HALF = 250;
  localparam int SAT      = 1023;
`ifdef FSK_DEMOD_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsk_in = 1'b0;
  logic data_out;
  logic carrier_ok;

  fsk_demod #(
    .CNT_W(10), .THRESH(THRESH), .MIN_HALF(MIN_HALF),
    .MAX_HALF(MAX_HALF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .fsk_in(fsk_in),
    .data_out(data_out), .carrier_ok(carrier_ok)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic d;
    logic c;
    int   tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: outputs and the last three accepted decisions
  logic m_data, m_car;
  int   hist[3];
  bit   m_first;
  int   last_t;
  int   tag_n = 0;

  function automatic void push(input int at);
    q.push_back(exp_t'{at, m_data, m_car, tag_n});
    tag_n++;
  endfunction

  function automatic void model_reset();
    m_data  = 1'b0;
    m_car   = 1'b0;
    hist    = '{0, 0, 0};
    m_first = 1'b1;
    last_t  = 0;
  endfunction

  function automatic void model_sample(input int s);
    logic b;
    if (s >= MIN_HALF && s <= MAX_HALF) begin
      m_car = 1'b1;
      b = (s < THRESH);
      if (MAJ != 0) begin
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int'(b);
        m_data  = ((hist[0] + hist[1] + hist[2]) >= 2);
      end else begin
        m_data = b;
      end
    end else if (s > MAX_HALF) begin
      m_car = 1'b0;
    end
  endfunction

  function automatic void model_timeout();
    m_car  = 1'b0;
    m_data = 1'b0;
    hist   = '{0, 0, 0};
  endfunction

  // Called at a negedge: toggle fsk_in, then hold the level for h cycles
  task automatic half(input int h);
    int t, s;
    fsk_in = ~fsk_in;
    t = cyc;
    s = m_first ? SAT : (t - last_t);
    if (s > SAT) s = SAT;
    m_first = 1'b0;
    last_t  = t;
    model_sample(s);
    push(t + 4 + MAJ);
    if (h > TIMEOUT) begin
      push(t + 3 + TIMEOUT - 1);
      model_timeout();
      push(t + 3 + TIMEOUT);
    end
    repeat (h) @(negedge clk);
  endtask

  task automatic burst(input int h, input int n);
    repeat (n) half(h);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compares DUT outputs whenever an expectation falls due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL chk%0d: missed at cyc %0d (now %0d), required data=%b car=%b",
                 e.tag, e.at, cyc, e.d, e.c);
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        total++;
        if (data_out !== e.d || carrier_ok !== e.c) begin
          bad++;
          $display("FAIL chk%0d cyc=%0d: got data=%b car=%b, required data=%b car=%b",
                   e.tag, cyc, data_out, carrier_ok, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int r, h;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(cyc + 1);
    repeat (1100) @(negedge clk);

    // First edge after long idle saturates; lock follows from the second edge
    half(184);
    burst(184, 6);
    burst(148, 6);
    burst(184, 4);
    // 20-clk pulse pair inside one space half-period
    half(82); half(20); half(82);
    burst(184, 3);
    // Threshold and acceptance-window boundaries
    half(165); half(166); half(250); half(251);
    burst(184, 3);
    burst(148, 4);
    drain();

    // Asynchronous reset mid-stream must clear outputs before the next clock
    @(posedge clk);
    #3;
    rst = 1'b1;
    fsk_in = 1'b0;
    model_reset();
    push(cyc);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    half(148);
    burst(148, 6);
    burst(184, 4);

    // Randomised mix of valid, glitch, overlong and carrier-loss gaps
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      h = $urandom_range(MIN_HALF, MAX_HALF);
      else if (r < 80) h = $urandom_range(20, MIN_HALF - 1);
      else if (r < 90) h = $urandom_range(MAX_HALF + 1, 400);
      else             h = $urandom_range(600, 800);
      half(h);
    end

    burst(148, 4);
    // Stop toggling: carrier lost exactly TIMEOUT clocks after the last edge
    half(700);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
